sa_feeder: RTL and testbench

Upstream operand feeder for the systolic array (SA). Holds one N×N signed A matrix and one N×N signed B matrix loaded over a valid/ready port. On `start` it streams them into the array as diagonally skewed, zero-padded lanes: A rows enter from the west, B columns from the north. It drives the array's `en` and accumulator clear, and pulses `done` once the last product has propagated.

---
 rtl/sa_feeder.sv | 164 ++++++++++++++++
 tb/tb_sa_feeder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_feeder.sv
// sa_feeder: operand feeder for an N x N signed systolic array.
// Holds one A and one B matrix, loaded row/column-wise over a valid/ready
// port, and on start streams them as diagonally skewed, zero-padded lanes:
// A rows to the west edge, B columns to the north edge.
// Optional feature macro: SA_FEEDER_CLR_EN adds a CLEAR state that pulses
// o_sa_clr before streaming, so every run yields a fresh product instead of
// accumulating into the array.
module sa_feeder #(
    parameter int WIDTH = 8,
    parameter int N     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load_valid,
    output logic                 o_load_ready,
    input  logic                 i_load_sel,
    input  logic [$clog2(N)-1:0] i_load_idx,
    input  logic [N*WIDTH-1:0]   i_load_data,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_sa_en,
    output logic                 o_sa_clr,
    output logic [N*WIDTH-1:0]   o_sa_a,
    output logic [N*WIDTH-1:0]   o_sa_b
);

    localparam int IDXW   = $clog2(N);
    localparam int STEPS  = 3*N - 2;          // stream length in cycles
    localparam int TW     = $clog2(STEPS);
    localparam int T_LAST = STEPS - 1;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_DONE} state_t;

    state_t                             r_state, w_state_nxt;
    logic [TW-1:0]                      r_t, w_t_nxt;
    logic [N-1:0][N-1:0][WIDTH-1:0]     r_a, r_b;       // [row][col]
    logic [N-1:0][N-1:0][WIDTH-1:0]     w_a_nxt, w_b_nxt;
    logic                               w_load_fire;
    logic                               w_sa_clr_d;
    logic [N*WIDTH-1:0]                 w_sa_a_d, w_sa_b_d;

    logic                               r_load_ready, r_busy, r_done, r_sa_en, r_sa_clr;
    logic [N*WIDTH-1:0]                 r_sa_a, r_sa_b;

    assign w_load_fire = i_load_valid & (r_state == S_IDLE);

    // State register and STREAM step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_t     <= '0;
        end else begin
            // NOTE: clocked blocks use <= so every flop samples pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
        end
    end

    // Next-state and next-step logic.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missed path would infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
`ifdef SA_FEEDER_CLR_EN
                    w_state_nxt = S_CLEAR;
`else
                    w_state_nxt = S_STREAM;
`endif
                end
            end
            S_CLEAR:  w_state_nxt = S_STREAM;
            S_STREAM: if (r_t == TW'(T_LAST)) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        w_t_nxt = ((r_state == S_STREAM) && (w_state_nxt == S_STREAM)) ? r_t + TW'(1) : '0;
    end

    // Storage update: an accepted beat overwrites one A row or one B column.
    // Index values >= N match no row and are silently dropped.
    always_comb begin
        w_a_nxt = r_a;
        w_b_nxt = r_b;
        if (w_load_fire) begin
            for (int r = 0; r < N; r++) begin
                if (i_load_idx == IDXW'(r)) begin
                    for (int k = 0; k < N; k++) begin
                        if (!i_load_sel) w_a_nxt[r][k] = i_load_data[k*WIDTH +: WIDTH];
                        else             w_b_nxt[k][r] = i_load_data[k*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // Matrix storage; persists across runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset on purpose so a run issued before any load streams zeros, never X.
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= w_a_nxt;
            r_b <= w_b_nxt;
        end
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they describe; lanes read the post-load storage so a load
    // accepted with start is already visible at t = 0.
    always_comb begin
        w_sa_a_d = '0;
        w_sa_b_d = '0;
        if (w_state_nxt == S_STREAM) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(w_t_nxt) == i + k) begin
                        w_sa_a_d[i*WIDTH +: WIDTH] = w_a_nxt[i][k];
                        w_sa_b_d[i*WIDTH +: WIDTH] = w_b_nxt[k][i];
                    end
                end
            end
        end
    end

`ifdef SA_FEEDER_CLR_EN
    assign w_sa_clr_d = (w_state_nxt == S_CLEAR);
`else
    assign w_sa_clr_d = 1'b0;
`endif

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_ready <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sa_en      <= 1'b0;
            r_sa_clr     <= 1'b0;
            r_sa_a       <= '0;
            r_sa_b       <= '0;
        end else begin
            r_load_ready <= (w_state_nxt == S_IDLE);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
            r_sa_en      <= (w_state_nxt == S_STREAM);
            r_sa_clr     <= w_sa_clr_d;
            r_sa_a       <= w_sa_a_d;
            r_sa_b       <= w_sa_b_d;
        end
    end

    assign o_load_ready = r_load_ready;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_sa_en      = r_sa_en;
    assign o_sa_clr     = r_sa_clr;
    assign o_sa_a       = r_sa_a;
    assign o_sa_b       = r_sa_b;

endmodule

// File: tb/tb_sa_feeder.sv
// Self-checking bench for sa_feeder (N=2, WIDTH=8). Expected lanes come from
// scattering each matrix element to its arrival time; a downstream array is
// modelled from the observed lanes and compared with a plain matrix product.
module tb_sa_feeder;

    localparam int WIDTH = 8;
    localparam int N     = 2;
    localparam int IDXW  = $clog2(N);
    localparam int STEPS = 3*N - 2;
    localparam int LW    = N*WIDTH;
`ifdef SA_FEEDER_CLR_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_load_valid, i_load_sel, i_start;
    logic [IDXW-1:0] i_load_idx;
    logic [LW-1:0]   i_load_data;
    logic            o_load_ready, o_busy, o_done, o_sa_en, o_sa_clr;
    logic [LW-1:0]   o_sa_a, o_sa_b;

    always #5 clk = ~clk;

    sa_feeder #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
        .i_load_sel(i_load_sel), .i_load_idx(i_load_idx), .i_load_data(i_load_data),
        .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_sa_en(o_sa_en), .o_sa_clr(o_sa_clr), .o_sa_a(o_sa_a), .o_sa_b(o_sa_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference state
    logic signed [WIDTH-1:0] ma [N][N];
    logic signed [WIDTH-1:0] mb [N][N];
    longint                  acc   [N][N];   // modelled downstream accumulators
    longint                  exp_c [N][N];   // expected accumulators
    longint                  prod  [N][N];   // product of the latest run
    logic [LW-1:0]           sk_a [STEPS], sk_b [STEPS];
    logic [LW-1:0]           ha [STEPS], hb [STEPS];

    typedef struct {
        logic [N*N*WIDTH-1:0] a;
        logic [N*N*WIDTH-1:0] b;
        logic [N*N*32-1:0]    c;
    } vec_t;
    vec_t tbl [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] stat();
        return {o_load_ready, o_busy, o_done, o_sa_en, o_sa_clr};
    endfunction

    task automatic clear_models(input bit mats);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc[i][j]   = 0;
                exp_c[i][j] = 0;
                if (mats) begin
                    ma[i][j] = '0;
                    mb[i][j] = '0;
                end
            end
    endtask

    task automatic apply_load(input bit sel, input int idx, input logic [LW-1:0] data);
        if (idx < N)
            for (int k = 0; k < N; k++)
                if (sel) mb[k][idx] = data[k*WIDTH +: WIDTH];
                else     ma[idx][k] = data[k*WIDTH +: WIDTH];
    endtask

    // Place each element on its lane at the time it must appear.
    task automatic build_skew();
        for (int t = 0; t < STEPS; t++) begin
            sk_a[t] = '0;
            sk_b[t] = '0;
        end
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                sk_a[i+k][i*WIDTH +: WIDTH] = ma[i][k];
                sk_b[i+k][i*WIDTH +: WIDTH] = mb[k][i];
            end
    endtask

    // One load beat in IDLE; called and returns at a negedge.
    task automatic beat(input bit sel, input int idx, input logic [LW-1:0] data);
        i_load_valid = 1'b1;
        i_load_sel   = sel;
        i_load_idx   = IDXW'(idx);
        i_load_data  = data;
        check("load_ready idle", o_load_ready, 1);
        @(negedge clk);
        i_load_valid = 1'b0;
        apply_load(sel, idx, data);
    endtask

    task automatic load_mats(input logic [N*N*WIDTH-1:0] a, input logic [N*N*WIDTH-1:0] b);
        logic [LW-1:0] col;
        for (int r = 0; r < N; r++) beat(1'b0, r, a[r*LW +: LW]);
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < N; k++) col[k*WIDTH +: WIDTH] = b[(k*N + j)*WIDTH +: WIDTH];
            beat(1'b1, j, col);
        end
    endtask

    // Full run from a negedge in IDLE to the negedge of the first IDLE cycle
    // afterwards. Optionally loads a beat together with start, and optionally
    // holds load_valid and pulses start while the run is in progress.
    task automatic run(input string tag, input bit with_load, input bit sel, input int idx,
                       input logic [LW-1:0] data, input bit disturb);
        logic [4:0] es;
        logic [2*LW-1:0] el;
        longint s;
        int t;
        i_start = 1'b1;
        if (with_load) begin
            i_load_valid = 1'b1;
            i_load_sel   = sel;
            i_load_idx   = IDXW'(idx);
            i_load_data  = data;
            apply_load(sel, idx, data);
        end
        build_skew();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (LAT == 1) exp_c[i][j] = 0;
                for (int k = 0; k < N; k++)
                    exp_c[i][j] += longint'(ma[i][k]) * longint'(mb[k][j]);
            end
        for (int c = 1; c <= STEPS + LAT + 2; c++) begin
            @(negedge clk);
            el = '0;
            if (LAT == 1 && c == 1)      es = 5'b01001;
            else if (c <= STEPS + LAT) begin
                es = 5'b01010;
                t  = c - 1 - LAT;
                el = {sk_a[t], sk_b[t]};
                ha[t] = o_sa_a;
                hb[t] = o_sa_b;
            end
            else if (c == STEPS + LAT + 1) es = 5'b01100;
            else                           es = 5'b10000;
            if (o_sa_clr)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) acc[i][j] = 0;
            check($sformatf("%s status c%0d", tag, c), stat(), es);
            check($sformatf("%s lanes c%0d", tag, c), {o_sa_a, o_sa_b}, el);
            i_start      = disturb && (c == 2 + LAT);
            i_load_valid = disturb && (c <= STEPS + LAT);
            if (disturb) begin
                i_load_sel  = 1'b0;
                i_load_idx  = '0;
                i_load_data = 16'h5A5A;
            end
        end
        // Downstream array: PE(i,j) sees west lane i delayed by j, north lane j delayed by i.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int tt = 0; tt < STEPS + N; tt++)
                    if (tt - j >= 0 && tt - j < STEPS && tt - i >= 0 && tt - i < STEPS)
                        s += $signed(ha[tt-j][i*WIDTH +: WIDTH]) * $signed(hb[tt-i][j*WIDTH +: WIDTH]);
                prod[i][j] = s;
                acc[i][j] += s;
                check($sformatf("%s C[%0d][%0d]", tag, i, j), acc[i][j], exp_c[i][j]);
            end
    endtask

    initial begin
        tbl[0].a = {8'd4, 8'd3, 8'd2, 8'd1};
        tbl[0].b = {8'd8, 8'd7, 8'd6, 8'd5};
        tbl[0].c = {32'd50, 32'd43, 32'd22, 32'd19};
        tbl[1].a = {8'h00, 8'hFF, 8'h7F, 8'h80};
        tbl[1].b = {8'd1, 8'd0, 8'd0, 8'd1};
        tbl[1].c = {32'h0, 32'hFFFF_FFFF, 32'd127, 32'hFFFF_FF80};

        rst_n = 1'b0;
        i_load_valid = 1'b0; i_load_sel = 1'b0; i_load_idx = '0; i_load_data = '0; i_start = 1'b0;
        clear_models(1'b1);
        repeat (3) begin
            @(negedge clk);
            check("reset status", stat(), 5'b10000);
            check("reset lanes", {o_sa_a, o_sa_b}, '0);
        end
        rst_n = 1'b1;

        // Table-driven runs from the documented examples.
        for (int v = 0; v < 2; v++) begin
            load_mats(tbl[v].a, tbl[v].b);
            run($sformatf("tbl%0d", v), 1'b0, 1'b0, 0, '0, 1'b0);
            for (int e = 0; e < N*N; e++)
                check($sformatf("tbl%0d product %0d", v, e), prod[e/N][e%N],
                      longint'($signed(tbl[v].c[e*32 +: 32])));
            if (v == 0) begin
                check("ex lanes t0", {ha[0], hb[0]}, 32'h0001_0005);
                check("ex lanes t1", {ha[1], hb[1]}, 32'h0302_0607);
                check("ex lanes t2", {ha[2], hb[2]}, 32'h0400_0800);
                check("ex lanes t3", {ha[3], hb[3]}, 32'h0000_0000);
            end else begin
                check("neg lane t0", ha[0][7:0], 8'h80);
                check("neg lane t1", ha[1], 16'hFF7F);
            end
        end

        // Back-to-back runs on a fresh array.
        load_mats(tbl[0].a, tbl[0].b);
        clear_models(1'b0);
        run("b2b first", 1'b0, 1'b0, 0, '0, 1'b0);
        run("b2b second", 1'b0, 1'b0, 0, '0, 1'b0);
        check("b2b C00", acc[0][0], (LAT == 1) ? 19 : 38);
        check("b2b C11", acc[1][1], (LAT == 1) ? 50 : 100);

        // Loads held and start pulsed mid-run are ignored; rerun shows storage intact.
        run("disturb", 1'b0, 1'b0, 0, '0, 1'b1);
        @(negedge clk);
        check("no queued start", stat(), 5'b10000);
        run("rerun", 1'b0, 1'b0, 0, '0, 1'b0);

        // Load and start in the same cycle: new row streams.
        run("load+start", 1'b1, 1'b0, 1, 16'h09F0, 1'b0);

        // Reset at STREAM t=1.
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (1 + LAT) @(negedge clk);
        check("midrun en", o_sa_en, 1);
        rst_n = 1'b0;
        #1;
        check("midrun rst status", stat(), 5'b10000);
        check("midrun rst lanes", {o_sa_a, o_sa_b}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_models(1'b1);
        run("post reset", 1'b0, 1'b0, 0, '0, 1'b0);

        // Randomized loads and runs.
        for (int it = 0; it < 10; it++) begin
            int nb;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++)
                beat(1'($urandom_range(0, 1)), $urandom_range(0, N-1), LW'($urandom));
            run($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, N-1), LW'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
